// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, the PC step,
// the bubble instruction, the run/idle state type and the IF/ID record.
package if_pkg;

    localparam int          XLEN                = 32;
    localparam logic [31:0] PC_STEP             = 32'd4;
    localparam logic [31:0] FLUSH_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    // Sequential successor of a PC; wraps modulo 2^32 with no carry out.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program-counter register with the sequential increment and next-PC mux.
// Priority of the decision inputs: flush > hold > advance; with none asserted
// the PC keeps its value.
module if_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            advance,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] next_pc_s;

    // Select the next PC: branch redirect, hold, or sequential step.
    always_comb begin
        next_pc_s = pc_r;
        if (flush) begin
            next_pc_s = target;  // taken unmodified, no alignment fix-up
        end else if (hold) begin
            next_pc_s = pc_r;
        end else if (advance) begin
            next_pc_s = next_seq_pc(pc_r);
        end else begin
            next_pc_s = pc_r;
        end
    end

    // PC register, asynchronously returned to RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: run/idle control, PC (via if_pc_reg) and the IF/ID
// pipeline register. Optional fetch/bubble statistics counters are enabled
// by defining IF_FETCH_STAT_EN.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] FLUSH_INSTR = FLUSH_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
`ifdef IF_FETCH_STAT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o,
`endif
    output logic        ifid_valid_o
);

    fetch_state_t state_r;
    ifid_t        ifid_r;

    logic run_edge_s;
    logic do_flush_s;
    logic do_hold_s;
    logic do_adv_s;

    // An edge does work only if already running and start_i is still high;
    // a start_i drop freezes the stage on the very edge that samples it.
    assign run_edge_s = (state_r == RUN) && start_i;
    assign do_flush_s = run_edge_s && flush_i;
    assign do_hold_s  = !run_edge_s || (stall_i && !flush_i);
    assign do_adv_s   = run_edge_s && !flush_i && !stall_i;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (do_flush_s),
        .hold    (do_hold_s),
        .advance (do_adv_s),
        .target  (branch_target_i),
        .pc      (pc_o)
    );

    // Run/idle state machine driven by the start handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= start_i ? RUN : IDLE;
                RUN:     state_r <= start_i ? RUN : IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // IF/ID register: bubble on flush, capture on advance, otherwise hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_r <= '{pc: 32'h0000_0000, instr: FLUSH_INSTR, valid: 1'b0};
        end else if (do_flush_s) begin
            ifid_r <= '{pc: 32'h0000_0000, instr: FLUSH_INSTR, valid: 1'b0};
        end else if (do_adv_s) begin
            ifid_r <= '{pc: pc_o, instr: instr_i, valid: 1'b1};
        end else begin
            ifid_r <= ifid_r;
        end
    end

    assign ifid_pc_o    = ifid_r.pc;
    assign ifid_instr_o = ifid_r.instr;
    assign ifid_valid_o = ifid_r.valid;

`ifdef IF_FETCH_STAT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Saturating counters of advancing edges and of flush/stall edges in RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_r  <= 32'h0000_0000;
            bubble_cnt_r <= 32'h0000_0000;
        end else begin
            if (do_adv_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
            if (run_edge_s && (flush_i || stall_i) && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_r;
    assign bubble_cnt_o = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a driver issues random and directed
// stimulus and pushes the expected post-edge outputs from a reference model;
// a monitor pops and compares one entry after every rising edge.
module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o, ifid_pc_o, ifid_instr_o;
    logic        ifid_valid_o;
    logic        start2;
    logic [31:0] instr2, pc2, ifid_pc2, ifid_instr2;
    logic        ifid_valid2;
`ifdef IF_FETCH_STAT_EN
    logic [31:0] fetch_cnt_o, bubble_cnt_o, fetch_cnt2, bubble_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] ifid_instr;
        logic        ifid_valid;
        logic [31:0] fetch;
        logic [31:0] bubble;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (higher-level view of the stage).
    bit          m_run;
    logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_fetch, m_bubble;
    logic        m_valid;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[7:0], 24'h00_0000};
    endfunction

    assign instr_i = mem(pc_o);
    assign instr2  = mem(pc2);

    always #5 clk_i = ~clk_i;

    if_fetch_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o),
`ifdef IF_FETCH_STAT_EN
        .fetch_cnt_o     (fetch_cnt_o),
        .bubble_cnt_o    (bubble_cnt_o),
`endif
        .ifid_valid_o    (ifid_valid_o)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start2),
        .stall_i         (1'b0),
        .flush_i         (1'b0),
        .branch_target_i (32'h0000_0000),
        .instr_i         (instr2),
        .pc_o            (pc2),
        .ifid_pc_o       (ifid_pc2),
        .ifid_instr_o    (ifid_instr2),
`ifdef IF_FETCH_STAT_EN
        .fetch_cnt_o     (fetch_cnt2),
        .bubble_cnt_o    (bubble_cnt2),
`endif
        .ifid_valid_o    (ifid_valid2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc = 32'h0000_0000;
        m_ifid_pc = 32'h0000_0000;
        m_ifid_instr = 32'h0000_0013;
        m_valid = 1'b0;
        m_fetch = 32'h0000_0000;
        m_bubble = 32'h0000_0000;
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs, advance a cycle.
    task automatic step(input logic s, input logic st, input logic fl, input logic [31:0] tg);
        exp_t e;
        start_i = s;
        stall_i = st;
        flush_i = fl;
        branch_target_i = tg;
        if (!m_run) begin
            m_run = s;
        end else if (!s) begin
            m_run = 1'b0;
        end else if (fl) begin
            if (m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
            m_pc = tg;
            m_ifid_pc = 32'h0000_0000;
            m_ifid_instr = 32'h0000_0013;
            m_valid = 1'b0;
        end else if (st) begin
            if (m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
        end else begin
            if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 32'd1;
            m_ifid_pc = m_pc;
            m_ifid_instr = mem(m_pc);
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e = '{pc: m_pc, ifid_pc: m_ifid_pc, ifid_instr: m_ifid_instr,
              ifid_valid: m_valid, fetch: m_fetch, bubble: m_bubble};
        exp_q.push_back(e);
        @(posedge clk_i);
        #2;
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc", pc_o, e.pc);
            chk("ifid_pc", ifid_pc_o, e.ifid_pc);
            chk("ifid_instr", ifid_instr_o, e.ifid_instr);
            chk("ifid_valid", {31'd0, ifid_valid_o}, {31'd0, e.ifid_valid});
`ifdef IF_FETCH_STAT_EN
            chk("fetch_cnt", fetch_cnt_o, e.fetch);
            chk("bubble_cnt", bubble_cnt_o, e.bubble);
`endif
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pc"}, pc_o, 32'h0000_0000);
        chk({tag, "_ifid_pc"}, ifid_pc_o, 32'h0000_0000);
        chk({tag, "_ifid_instr"}, ifid_instr_o, 32'h0000_0013);
        chk({tag, "_ifid_valid"}, {31'd0, ifid_valid_o}, 32'd0);
`ifdef IF_FETCH_STAT_EN
        chk({tag, "_fetch_cnt"}, fetch_cnt_o, 32'd0);
        chk({tag, "_bubble_cnt"}, bubble_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        int guard;
        rst_i = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        branch_target_i = 32'h0000_0000;
        start2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        chk_reset_values("reset");
        chk("wrap_reset_pc", pc2, 32'hFFFF_FFF8);

        // Idle: stall/flush must be ignored.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom());

        // Start and run to 0x20, stall twice, run to 0x30.
        guard = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        while (m_pc != 32'h20 && guard < 50) begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        guard = 0;
        while (m_pc != 32'h30 && guard < 50) begin step(1'b1, 1'b0, 1'b0, 32'h0); guard++; end
        // Branch redirect, then flush+stall together, then wrap-around.
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        // Freeze mid-stream and resume; an unaligned target too.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0777);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] tg;
            tg = $urandom();
            if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
            step(1'($urandom_range(9) != 0), 1'($urandom_range(3) == 0),
                 1'($urandom_range(6) == 0), tg);
        end

        // Asynchronous reset mid-cycle while running.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b1;
        #1;
        chk_reset_values("async_reset");
        #1;
        rst_i = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);  // first edge only re-enters RUN
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'($urandom_range(3) == 0), 1'($urandom_range(6) == 0), $urandom() & 32'hFFFF_FFFC);

        // RESET_PC near the top of the address space wraps to zero.
        start2 = 1'b1;
        @(posedge clk_i); #1;
        chk("wrap_pc_after_start", pc2, 32'hFFFF_FFF8);
        @(posedge clk_i); #1;
        chk("wrap_pc_1", pc2, 32'hFFFF_FFFC);
        chk("wrap_ifid_pc_1", ifid_pc2, 32'hFFFF_FFF8);
        chk("wrap_ifid_instr_1", ifid_instr2, mem(32'hFFFF_FFF8));
        @(posedge clk_i); #1;
        chk("wrap_pc_2", pc2, 32'h0000_0000);
        chk("wrap_ifid_valid_2", {31'd0, ifid_valid2}, 32'd1);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined CPU: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. Each cycle it selects the next PC: sequential PC+4, or a taken-branch target computed by the branch-target adder in ID. It also applies hazard-unit stalls and branch flushes. A start handshake gates execution after reset.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FLUSH_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) written into IF/ID on flush and reset
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  run enable; low holds the stage idle
- stall_i  in  1  hazard-unit stall request (load-use)
- flush_i  in  1  branch taken in ID; redirect PC, squash IF/ID
- branch_target_i  in  32  taken-branch target from branch-target adder
- instr_i  in  32  instruction-memory read data for pc_o (combinational read)
- pc_o  out  32  current PC / instruction-memory address
- ifid_pc_o  out  32  PC of instruction held in IF/ID
- ifid_instr_o  out  32  instruction held in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real fetched instruction

## Operation
- FSM states: IDLE, RUN. Reset -> IDLE. IDLE -> RUN when start_i=1 at an edge. RUN -> IDLE when start_i=0 at an edge.
- IDLE: PC and IF/ID hold. stall_i and flush_i are ignored.
- RUN, per edge, priority flush_i > stall_i > advance:
  - flush_i=1: PC <= branch_target_i; IF/ID <= {pc: 0, instr: FLUSH_INSTR, valid: 0}. This holds even if stall_i=1.
  - stall_i=1 (no flush): PC and IF/ID hold all fields.
  - otherwise: PC <= PC+4; IF/ID <= {pc_o, instr_i, 1}.
- Arithmetic: PC+4 is 32-bit, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No carry out.
- branch_target_i is taken unmodified, with no alignment check or correction.
- Reset values: pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=FLUSH_INSTR, ifid_valid_o=0, state IDLE.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Fetching resumes only after a new IDLE->RUN transition.

## Timing
- Every register updates on the rising edge of clk_i. rst_i is the only asynchronous input.
- pc_o is a registered output. instr_i must be valid combinationally within the same cycle.
- Start latency: start_i first sampled high at edge N -> RUN after N. PC first advances at edge N+1. First valid IF/ID entry is visible after N+1.
- Flush: flush_i sampled at edge N -> pc_o = target after N. IF/ID is a bubble after N. The target instruction reaches IF/ID after N+1.
- Stall: one held cycle per cycle that stall_i is high. No instruction is lost or duplicated.
- start_i low mid-stream: the freeze takes effect at the sampling edge. Resuming continues from the held PC.

## Configuration
- Macro: IF_FETCH_STAT_EN.
- Defined: adds two outputs, fetch_cnt_o [31:0] and bubble_cnt_o [31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - fetch_cnt_o increments on each RUN advance edge.
  - bubble_cnt_o increments on each RUN edge with flush_i or stall_i high.
  - IDLE cycles are not counted.
- Undefined: neither port nor counter logic exists; the rest of the behaviour is identical.

## Structure
- Shared package if_pkg:
  - XLEN=32
  - PC_STEP=4
  - default FLUSH_INSTR constant
  - FSM state typedef (IDLE, RUN)
  - IF/ID record typedef {pc, instr, valid}
- One sub-module, if_pc_reg: PC register, PC+4 increment and next-PC mux, with inputs for the flush, hold and advance decisions. The top module keeps the FSM, the IF/ID register and the optional counters.

## Test plan
- Reset, start_i=0 for 5 cycles -> pc_o=0, ifid_valid_o=0, ifid_instr_o=32'h13 throughout. Then start_i=1 -> pc_o runs 0,4,8. IF/ID shows (0,instr@0,1) two edges after start.
- RUN at pc_o=32'h20, stall_i=1 for 2 cycles -> pc_o stays 32'h20 and IF/ID is unchanged for 2 cycles. Then pc_o=32'h24.
- flush_i=1 with branch_target_i=32'h100 at pc_o=32'h30 -> next pc_o=32'h100, IF/ID bubble (valid=0, instr=32'h13). Next edge loads IF/ID=(32'h100, instr@100, 1).
- flush_i=1 and stall_i=1 together, target 32'h40 -> flush wins: pc_o=32'h40, IF/ID bubble.
- RESET_PC=32'hFFFF_FFF8 in RUN -> pc_o runs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_i pulsed asynchronously mid-cycle in RUN -> outputs at reset values before the next edge, state IDLE. With IF_FETCH_STAT_EN, counters read 0.
